// File: rtl/mc_wvb_reader.sv
// mc_wvb_reader: round-robin copies multi-channel waveform-buffer events into a direct-readout DPRAM
// as word-framed records and hands each filled buffer to the readout engine via run/busy.
module mc_wvb_reader #(
  parameter int N_CHANNELS  = 4,
  parameter int HDR_W       = 80,
  parameter int WVB_W       = 22,
  parameter int DPRAM_W     = 32,
  parameter int P_ADR_W     = 10,
  parameter int FILL_THRESH = 768
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        dpram_mode,
  input  logic [N_CHANNELS-1:0]       hdr_empty,
  input  logic [N_CHANNELS*HDR_W-1:0] hdr_data,
  output logic [N_CHANNELS-1:0]       hdr_rdreq,
  input  logic [N_CHANNELS*WVB_W-1:0] wvb_data,
  output logic [N_CHANNELS-1:0]       wvb_rdreq,
  output logic [N_CHANNELS-1:0]       wvb_rddone,
  output logic [DPRAM_W-1:0]          dpram_data,
  output logic [P_ADR_W-1:0]          dpram_addr,
  output logic                        dpram_wren,
  output logic [15:0]                 dpram_len,
  output logic                        dpram_run,
  input  logic                        dpram_busy,
  output logic [15:0]                 n_events
);
  localparam int HW  = (HDR_W + DPRAM_W - 1) / DPRAM_W;
  localparam int CW  = N_CHANNELS > 1 ? $clog2(N_CHANNELS) : 1;
  localparam int HIW = HW > 1 ? $clog2(HW) : 1;
  // last address a sample may occupy; the final DPRAM word is never written
  localparam logic [P_ADR_W-1:0] LAST_SAMP = {{(P_ADR_W-1){1'b1}}, 1'b0};
  typedef enum logic [2:0] {IDLE, ARB, HDR, SAMP, DRAIN, PATCH, RUN, WAIT} state_t;
  state_t               r_state;
  logic [CW-1:0]        r_ptr, r_chan, w_grant;
  logic [P_ADR_W-1:0]   r_base, r_addr, r_wp;
  logic [HIW-1:0]       r_hidx;
  logic [15:0]          r_cnt;
  logic                 r_trunc, r_first;
  logic                 w_any, w_hdr_last;
  logic [N_CHANNELS-1:0] w_sel;
  logic [HW*DPRAM_W-1:0] w_hdr;
  logic [WVB_W-1:0]     w_samp;
  assign w_any      = |(~hdr_empty);
  assign w_sel      = N_CHANNELS'(1) << r_chan;
  assign w_hdr      = (HW*DPRAM_W)'(hdr_data[r_chan*HDR_W +: HDR_W]);
  assign w_samp     = wvb_data[r_chan*WVB_W +: WVB_W];
  assign w_hdr_last = r_hidx == HIW'(HW-1);
  assign hdr_rdreq  = (r_state == HDR && w_hdr_last) ? w_sel : '0;
  assign wvb_rdreq  = (r_state == SAMP || r_state == DRAIN) ? w_sel : '0;
  // later iterations are closer to ptr+1, so the first pending channel after ptr wins
  always_comb begin
    w_grant = r_ptr;
    for (int k = N_CHANNELS; k >= 1; k--) begin
      int j;
      j = int'(r_ptr) + k;
      if (j >= N_CHANNELS) j = j - N_CHANNELS;
      if (!hdr_empty[j]) w_grant = CW'(j);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_chan     <= '0;
      r_base     <= '0;
      r_addr     <= '0;
      r_wp       <= '0;
      r_hidx     <= '0;
      r_cnt      <= '0;
      r_trunc    <= 1'b0;
      r_first    <= 1'b0;
      dpram_data <= '0;
      dpram_addr <= '0;
      dpram_wren <= 1'b0;
      dpram_len  <= '0;
      dpram_run  <= 1'b0;
      wvb_rddone <= '0;
      n_events   <= '0;
    end else begin
      dpram_wren <= 1'b0;
      dpram_run  <= 1'b0;
      dpram_len  <= '0;
      wvb_rddone <= '0;
      case (r_state)
        IDLE: if (en && !dpram_busy && w_any) r_state <= ARB;
        ARB: begin
          r_chan  <= w_grant;
          r_ptr   <= w_grant;
          r_base  <= r_wp;
          r_addr  <= r_wp + 1'b1;
          r_hidx  <= '0;
          r_cnt   <= '0;
          r_trunc <= 1'b0;
          r_state <= HDR;
        end
        HDR: begin
          dpram_wren <= 1'b1;
          dpram_addr <= r_addr;
          dpram_data <= w_hdr[r_hidx*DPRAM_W +: DPRAM_W];
          r_addr     <= r_addr + 1'b1;
          r_hidx     <= r_hidx + 1'b1;
          if (w_hdr_last) r_state <= SAMP;
        end
        SAMP: begin
          dpram_wren <= 1'b1;
          dpram_addr <= r_addr;
          dpram_data <= DPRAM_W'(w_samp);
          r_addr     <= r_addr + 1'b1;
          r_cnt      <= r_cnt + {15'b0, r_cnt != 16'hFFFF};
          if (w_samp[0]) r_state <= PATCH;
          else if (r_addr >= LAST_SAMP) begin
            r_trunc <= 1'b1;
            r_state <= DRAIN;
          end
        end
        DRAIN: if (w_samp[0]) r_state <= PATCH;
        PATCH: begin
          dpram_wren <= 1'b1;
          dpram_addr <= r_base;
          dpram_data <= DPRAM_W'({4'hE, 4'(r_chan), 7'b0, r_trunc, r_cnt});
          wvb_rddone <= w_sel;
          n_events   <= n_events + 1'b1;
          r_wp       <= r_addr;
          r_state    <= (dpram_mode && 32'(r_addr) < 32'(FILL_THRESH) && w_any) ? ARB : RUN;
        end
        RUN: begin
          dpram_run <= 1'b1;
          dpram_len <= 16'(r_wp);
          r_first   <= 1'b1;
          r_state   <= WAIT;
        end
        WAIT: begin
          r_first <= 1'b0;
          if (!r_first && !dpram_busy) begin
            r_wp     <= '0;
            n_events <= '0;
            r_state  <= IDLE;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_mc_wvb_reader.sv
// tb_mc_wvb_reader: randomized self-checking bench for mc_wvb_reader
// against a queue-based model of the record/packing rules.
module tb_mc_wvb_reader;
  localparam int N = 4, HDR_W = 80, WVB_W = 22, DW = 32, AW = 6, FILL = 40;
  localparam int HW = (HDR_W + DW - 1) / DW;
  localparam int DEPTH = 1 << AW;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, dpram_mode = 1'b0, dpram_busy = 1'b0;
  logic [N-1:0] hdr_empty = '1, hdr_rdreq, wvb_rdreq, wvb_rddone;
  logic [N*HDR_W-1:0] hdr_data = '0;
  logic [N*WVB_W-1:0] wvb_data = '0;
  logic [DW-1:0] dpram_data;
  logic [AW-1:0] dpram_addr;
  logic dpram_wren, dpram_run;
  logic [15:0] dpram_len, n_events;
  int n_chk = 0, n_fail = 0;
  logic [HDR_W-1:0] hq[N][$], mhq[N][$];
  logic [WVB_W-1:0] sq[N][$], msq[N][$];
  logic [DW-1:0] mem[DEPTH], exp_mem[DEPTH];
  int exp_len, exp_nev, m_ptr = 0, cyc = 0, first_wr = -1, run_cyc = 0, busy_cnt = 0, rd_cnt = 0;
  bit run_seen = 0, wr_seen = 0;
  logic [15:0] run_len, run_nev;
  logic [N-1:0] hs, ws;

  always #5 clk = ~clk;

  mc_wvb_reader #(.N_CHANNELS(N), .HDR_W(HDR_W), .WVB_W(WVB_W), .DPRAM_W(DW),
                  .P_ADR_W(AW), .FILL_THRESH(FILL)) dut (
    .clk(clk), .rst(rst), .en(en), .dpram_mode(dpram_mode),
    .hdr_empty(hdr_empty), .hdr_data(hdr_data), .hdr_rdreq(hdr_rdreq),
    .wvb_data(wvb_data), .wvb_rdreq(wvb_rdreq), .wvb_rddone(wvb_rddone),
    .dpram_data(dpram_data), .dpram_addr(dpram_addr), .dpram_wren(dpram_wren),
    .dpram_len(dpram_len), .dpram_run(dpram_run), .dpram_busy(dpram_busy),
    .n_events(n_events));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    for (int k = 0; k < N; k++) begin
      hdr_empty[k] = hq[k].size() == 0;
      hdr_data[k*HDR_W +: HDR_W] = hq[k].size() != 0 ? hq[k][0] : '0;
      wvb_data[k*WVB_W +: WVB_W] = sq[k].size() != 0 ? sq[k][0] : '0;
    end
  endtask

  // one clock: observe outputs at negedge, apply FIFO pops and busy just after posedge
  task automatic tick();
    @(negedge clk);
    cyc++;
    hs = hdr_rdreq;
    ws = wvb_rdreq;
    if (dpram_wren) begin
      mem[dpram_addr] = dpram_data;
      wr_seen = 1;
      if (first_wr < 0) first_wr = cyc;
    end
    if (dpram_busy) chk("busy_quiet", 64'(dpram_wren), 0);
    rd_cnt += $countones(wvb_rddone);
    if (dpram_run) begin
      run_seen = 1;
      run_cyc = cyc;
      run_len = dpram_len;
      run_nev = n_events;
      busy_cnt = 1 + $urandom_range(4);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (hs[k] && hq[k].size() != 0) hq[k].delete(0);
      if (ws[k] && sq[k].size() != 0) sq[k].delete(0);
    end
    dpram_busy = busy_cnt > 0;
    if (busy_cnt > 0) busy_cnt--;
    refresh();
  endtask

  task automatic add_event(input int ch, input int n);
    logic [HDR_W-1:0] h;
    logic [WVB_W-1:0] s;
    h = HDR_W'({$urandom, $urandom, $urandom});
    hq[ch].push_back(h);
    mhq[ch].push_back(h);
    for (int i = 0; i < n; i++) begin
      s = WVB_W'($urandom);
      s[0] = (i == n - 1);
      sq[ch].push_back(s);
      msq[ch].push_back(s);
    end
    refresh();
  endtask

  function automatic bit any_pending();
    for (int k = 0; k < N; k++) if (mhq[k].size() != 0) return 1;
    return 0;
  endfunction

  // expected contents of one handed-off buffer
  task automatic model_buffer(input bit mode);
    int base, cnt, room, ch;
    bit tr;
    logic [WVB_W-1:0] s;
    logic [HW*DW-1:0] hx;
    exp_len = 0;
    exp_nev = 0;
    do begin
      ch = -1;
      for (int k = 1; k <= N; k++) if (ch < 0 && mhq[(m_ptr + k) % N].size() != 0) ch = (m_ptr + k) % N;
      m_ptr = ch;
      base = exp_len;
      hx = (HW*DW)'(mhq[ch].pop_front());
      for (int j = 0; j < HW; j++) exp_mem[base + 1 + j] = hx[j*DW +: DW];
      room = DEPTH - 2 - base - HW;
      cnt = 0;
      tr = 0;
      do begin
        s = msq[ch].pop_front();
        if (cnt < room) begin
          exp_mem[base + 1 + HW + cnt] = DW'(s);
          cnt++;
        end else tr = 1;
      end while (!s[0]);
      exp_mem[base] = {4'hE, 4'(ch), 7'b0, tr, 16'(cnt)};
      exp_len = base + 1 + HW + cnt;
      exp_nev++;
    end while (mode && exp_len < FILL && any_pending());
  endtask

  task automatic run_round(input bit mode);
    dpram_mode = mode;
    en = 1;
    while (any_pending()) begin
      model_buffer(mode);
      for (int t = 0; t < 3000 && !run_seen; t++) tick();
      chk("run_seen", 64'(run_seen), 1);
      if (!run_seen) return;
      run_seen = 0;
      chk("len", 64'(run_len), 64'(exp_len));
      chk("n_events", 64'(run_nev), 64'(exp_nev));
      chk("rddone", 64'(rd_cnt), 64'(exp_nev));
      rd_cnt = 0;
      for (int a = 0; a < exp_len; a++) begin
        chk($sformatf("mem[%0d]", a), 64'(mem[a]), 64'(exp_mem[a]));
        mem[a] = 'x;
      end
    end
    for (int t = 0; t < 20; t++) tick();
    chk("no_extra_run", 64'(run_seen), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    refresh();
    repeat (3) tick();
    chk("rst_ctrl", 64'({hdr_rdreq, wvb_rdreq, wvb_rddone, dpram_wren, dpram_run, dpram_len, n_events, dpram_addr}), 0);
    chk("rst_data", 64'(dpram_data), 0);
    rst = 0;
    add_event(0, 10);
    repeat (20) tick();
    chk("en_gate", 64'(wr_seen), 0);
    first_wr = -1;
    run_round(0);
    chk("latency", 64'(run_cyc - first_wr), 64'(HW + 10 + 1));
    add_event(1, 10);
    add_event(3, 10);
    run_round(0);
    for (int k = 0; k < N; k++) add_event(k, 10);
    run_round(1);
    add_event(0, 10);
    add_event(2, 10);
    run_round(1);
    add_event(2, 70);
    add_event(1, 59);
    add_event(3, 60);
    run_round(0);
    add_event(1, 30);
    dpram_mode = 0;
    en = 1;
    for (int t = 0; t < 100 && wvb_rdreq == '0; t++) tick();
    chk("reached_samp", 64'(wvb_rdreq != '0), 1);
    tick();
    tick();
    rst = 1;
    #1;
    chk("rst_mid_ctrl", 64'({hdr_rdreq, wvb_rdreq, wvb_rddone, dpram_wren, dpram_run, dpram_len, n_events, dpram_addr}), 0);
    chk("rst_mid_data", 64'(dpram_data), 0);
    repeat (2) tick();
    for (int k = 0; k < N; k++) begin
      hq[k].delete();
      sq[k].delete();
      mhq[k].delete();
      msq[k].delete();
    end
    m_ptr = 0;
    run_seen = 0;
    rd_cnt = 0;
    busy_cnt = 0;
    refresh();
    rst = 0;
    repeat (10) tick();
    chk("no_run_after_rst", 64'(run_seen), 0);
    add_event(1, 5);
    add_event(3, 5);
    run_round(0);
    for (int r = 0; r < 12; r++) begin
      int ne;
      ne = 1 + $urandom_range(5);
      for (int e = 0; e < ne; e++)
        add_event($urandom_range(N - 1), ($urandom_range(7) == 0) ? 50 + $urandom_range(29) : 1 + $urandom_range(19));
      run_round(1'($urandom_range(1)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
